// File: rtl/spi_cfg_sequencer_if.sv
// Bus bundle between the SPI config sequencer, its register table and the SPI master.
// master = sequencer side, slave = table / SPI master / host side.
interface spi_cfg_sequencer_if;
   logic        cfg_go;
   logic [7:0]  tbl_idx;
   logic [14:0] tbl_addr;
   logic [7:0]  tbl_data;
   logic        spi_ready;
   logic        spi_start;
   logic        spi_rw;
   logic [14:0] spi_addr;
   logic [7:0]  spi_wdata;
   logic [7:0]  spi_rdata;
   logic        spi_rdata_vld;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_err;
   logic [7:0]  err_idx;

   modport master (
      input  cfg_go, tbl_addr, tbl_data,
      input  spi_ready, spi_rdata, spi_rdata_vld,
      output tbl_idx, spi_start, spi_rw,
      output spi_addr, spi_wdata,
      output cfg_busy, cfg_done, cfg_err, err_idx
   );

   modport slave (
      output cfg_go, tbl_addr, tbl_data,
      output spi_ready, spi_rdata, spi_rdata_vld,
      input  tbl_idx, spi_start, spi_rw,
      input  spi_addr, spi_wdata,
      input  cfg_busy, cfg_done, cfg_err, err_idx
   );
endinterface

// File: rtl/spi_cfg_sequencer.sv
// Walks a register table and issues one SPI write per entry with an idle gap between transfers.
// Define SPI_CFG_READBACK_EN to follow each write with a verifying read of the same address.
module spi_cfg_sequencer #(
   parameter int          NUM_REGS   = 16,
   parameter logic [11:0] GAP_CYCLES = 12'd2001
) (
   input logic                 clk,
   input logic                 rstn,
   spi_cfg_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_RDY, S_GAP,
      S_START, S_WAIT_ACK, S_WAIT_DONE, S_FIN
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

   state_t      r_state;
   state_t      w_nxt;
   logic [11:0] r_gap_cnt;
   logic [7:0]  r_idx;
   logic        r_rw;
   logic [14:0] r_addr;
   logic [7:0]  r_wdata;
   logic        r_busy;
   logic        r_done;
   logic        w_go_acc;
   logic        w_xfer_end;
   logic        w_rd_pend;
   logic        w_last;

   assign w_last = (r_idx == LAST_IDX);

`ifdef SPI_CFG_READBACK_EN
   assign w_rd_pend = ~r_rw;
`else
   assign w_rd_pend = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_nxt;
   end

   always_comb begin
      w_nxt      = r_state;
      w_go_acc   = 1'b0;
      w_xfer_end = 1'b0;
      unique case (r_state)
         S_IDLE, S_FIN: begin
            if (bus.cfg_go) begin
               w_go_acc = 1'b1;
               w_nxt    = S_FETCH;
            end
         end
         S_FETCH:    w_nxt = S_WAIT_RDY;
         S_WAIT_RDY: if (bus.spi_ready) w_nxt = S_GAP;
         S_GAP: begin
            if (!bus.spi_ready)              w_nxt = S_WAIT_RDY;
            else if (r_gap_cnt == GAP_CYCLES) w_nxt = S_START;
         end
         S_START:    w_nxt = S_WAIT_ACK;
         S_WAIT_ACK: if (!bus.spi_ready) w_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (bus.spi_ready) begin
               w_xfer_end = 1'b1;
               if (w_rd_pend)   w_nxt = S_WAIT_RDY;
               else if (w_last) w_nxt = S_FIN;
               else             w_nxt = S_FETCH;
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   // WAIT_RDY keeps the counter parked at 1 so a ready drop restarts the gap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_gap_cnt <= 12'd0;
      end else if (r_state == S_WAIT_RDY) begin
         r_gap_cnt <= 12'd1;
      end else if (r_state == S_GAP) begin
         r_gap_cnt <= r_gap_cnt + 12'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_idx   <= 8'd0;
         r_rw    <= 1'b0;
         r_addr  <= 15'd0;
         r_wdata <= 8'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (w_go_acc) begin
            r_idx  <= 8'd0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end
         if (r_state == S_FETCH) begin
            r_addr  <= bus.tbl_addr;
            r_wdata <= bus.tbl_data;
            r_rw    <= 1'b0;
         end
         if (w_xfer_end) begin
            if (w_rd_pend) begin
               r_rw <= 1'b1;
            end else if (w_last) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_idx <= r_idx + 8'd1;
            end
         end
      end
   end

`ifdef SPI_CFG_READBACK_EN
   logic       r_rd_seen;
   logic       r_rd_bad;
   logic       r_err;
   logic [7:0] r_err_idx;
   logic       w_vld;
   logic       w_rd_fail;

   // Only strobes during the read phase count; a missing strobe is a failure.
   assign w_vld     = bus.spi_rdata_vld & r_rw;
   assign w_rd_fail = r_rd_bad
                    | (w_vld & (bus.spi_rdata != r_wdata))
                    | ~(r_rd_seen | w_vld);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_seen <= 1'b0;
         r_rd_bad  <= 1'b0;
         r_err     <= 1'b0;
         r_err_idx <= 8'd0;
      end else begin
         if (w_go_acc) begin
            r_err     <= 1'b0;
            r_err_idx <= 8'd0;
         end
         if (r_state == S_FETCH) begin
            r_rd_seen <= 1'b0;
            r_rd_bad  <= 1'b0;
         end else if (w_vld) begin
            r_rd_seen <= 1'b1;
            if (bus.spi_rdata != r_wdata) r_rd_bad <= 1'b1;
         end
         if (w_xfer_end && r_rw && w_rd_fail && !r_err) begin
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
         end
      end
   end

   assign bus.cfg_err = r_err;
   assign bus.err_idx = r_err_idx;
`else
   logic w_unused_rb;
   assign w_unused_rb = ^{bus.spi_rdata, bus.spi_rdata_vld};
   assign bus.cfg_err = 1'b0;
   assign bus.err_idx = 8'd0;
`endif

   assign bus.tbl_idx   = r_idx;
   assign bus.spi_start = (r_state == S_START);
   assign bus.spi_rw    = r_rw;
   assign bus.spi_addr  = r_addr;
   assign bus.spi_wdata = r_wdata;
   assign bus.cfg_busy  = r_busy;
   assign bus.cfg_done  = r_done;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer: 3-entry table, 4-cycle gap, SPI master model
// that drops ready one cycle after start and holds it low for 10 cycles.
module tb_spi_cfg_sequencer;
   localparam int          NR  = 3;
   localparam logic [11:0] GAP = 12'd4;
   localparam int          LOW = 10;
`ifdef SPI_CFG_READBACK_EN
   localparam int PER = 2;
`else
   localparam int PER = 1;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   spi_cfg_sequencer_if bus();

   spi_cfg_sequencer #(.NUM_REGS(NR), .GAP_CYCLES(GAP)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   logic [14:0] t_addr [NR] = '{15'h0012, 15'h7ABC, 15'h4001};
   logic [7:0]  t_data [NR] = '{8'h3C, 8'h5A, 8'hC3};

   always_comb begin
      bus.tbl_addr = 15'd0;
      bus.tbl_data = 8'd0;
      for (int i = 0; i < NR; i++) begin
         if (bus.tbl_idx == 8'(i)) begin
            bus.tbl_addr = t_addr[i];
            bus.tbl_data = t_data[i];
         end
      end
   end

   // SPI master model
   logic        m_rdy;
   logic        force_low = 1'b0;
   logic        corrupt = 1'b0;
   int          m_cnt;
   logic        m_rw;
   logic [7:0]  m_wd;
   logic [14:0] m_addr;

   assign bus.spi_ready = m_rdy & ~force_low;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_rdy             <= 1'b1;
         m_cnt             <= 0;
         m_rw              <= 1'b0;
         m_wd              <= 8'd0;
         m_addr            <= 15'd0;
         bus.spi_rdata     <= 8'd0;
         bus.spi_rdata_vld <= 1'b0;
      end else begin
         bus.spi_rdata_vld <= 1'b0;
         if (bus.spi_start && m_rdy) begin
            m_rdy  <= 1'b0;
            m_cnt  <= LOW;
            m_rw   <= bus.spi_rw;
            m_wd   <= bus.spi_wdata;
            m_addr <= bus.spi_addr;
         end else if (!m_rdy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 5) begin
               bus.spi_rdata_vld <= 1'b1;
               if (!m_rw)
                  bus.spi_rdata <= 8'hFF;
               else if (corrupt && m_addr == t_addr[1])
                  bus.spi_rdata <= 8'hA5;
               else
                  bus.spi_rdata <= m_wd;
            end
            if (m_cnt == 1) m_rdy <= 1'b1;
         end
      end
   end

   // cycle counter and start monitor
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_st = 0;
   int          dbl = 0;
   logic        prev_st = 1'b0;
   int          st_t  [64];
   logic [14:0] st_a  [64];
   logic [7:0]  st_d  [64];
   logic        st_rw [64];

   always @(negedge clk) begin
      if (bus.spi_start) begin
         if (prev_st) dbl = dbl + 1;
         if (n_st < 64) begin
            st_t[n_st]  = cyc;
            st_a[n_st]  = bus.spi_addr;
            st_d[n_st]  = bus.spi_wdata;
            st_rw[n_st] = bus.spi_rw;
         end
         n_st = n_st + 1;
      end
      prev_st = bus.spi_start;
   end

   int total = 0;
   int bad = 0;

   task automatic go(output int t0);
      @(negedge clk);
      bus.cfg_go = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.cfg_go = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.cfg_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2 rstn = 1'b0;
      #20;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      total++; if (bus.spi_start !== 1'b0) begin bad++; $display("FAIL rst_start got %b want 0", bus.spi_start); end
      total++; if (bus.spi_rw !== 1'b0) begin bad++; $display("FAIL rst_rw got %b want 0", bus.spi_rw); end
      total++; if (bus.spi_addr !== 15'd0) begin bad++; $display("FAIL rst_addr got %h want 0", bus.spi_addr); end
      total++; if (bus.spi_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata got %h want 0", bus.spi_wdata); end
      total++; if (bus.tbl_idx !== 8'd0) begin bad++; $display("FAIL rst_idx got %h want 0", bus.tbl_idx); end
      total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", bus.cfg_busy); end
      total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", bus.cfg_done); end
      total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", bus.cfg_err); end
      total++; if (bus.err_idx !== 8'd0) begin bad++; $display("FAIL rst_err_idx got %h want 0", bus.err_idx); end
      repeat (30) @(negedge clk);
      total++; if (n_st !== 0) begin bad++; $display("FAIL no_autostart starts got %0d want 0", n_st); end
      total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b want 0", bus.cfg_busy); end
   endtask

   task automatic test_sequence;
      int t0, base, et, e;
      bit ok;
      base = n_st;
      go(t0);
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL seq_done_timeout got 0 want 1"); end
      total++; if (n_st - base !== NR * PER) begin bad++; $display("FAIL seq_count got %0d want %0d", n_st - base, NR * PER); end
      et = t0 + 6;
      for (int k = 0; k < NR * PER; k++) begin
         e = k / PER;
         if (k > 0) et += (PER == 2 && k % 2 == 1) ? 17 : 18;
         total++; if (st_a[base+k] !== t_addr[e]) begin bad++; $display("FAIL seq_addr[%0d] got %h want %h", k, st_a[base+k], t_addr[e]); end
         total++; if (st_d[base+k] !== t_data[e]) begin bad++; $display("FAIL seq_data[%0d] got %h want %h", k, st_d[base+k], t_data[e]); end
         total++; if (st_rw[base+k] !== 1'(k % PER)) begin bad++; $display("FAIL seq_rw[%0d] got %b want %b", k, st_rw[base+k], 1'(k % PER)); end
         total++; if (st_t[base+k] !== et) begin bad++; $display("FAIL seq_time[%0d] got %0d want %0d", k, st_t[base+k], et); end
      end
      total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL seq_busy got %b want 0", bus.cfg_busy); end
      total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL seq_err got %b want 0", bus.cfg_err); end
      total++; if (dbl !== 0) begin bad++; $display("FAIL start_width wide pulses got %0d want 0", dbl); end
      repeat (20) @(negedge clk);
      total++; if (bus.tbl_idx !== 8'(NR - 1)) begin bad++; $display("FAIL fin_idx got %0d want %0d", bus.tbl_idx, NR - 1); end
      total++; if (n_st - base !== NR * PER) begin bad++; $display("FAIL fin_quiet got %0d want %0d", n_st - base, NR * PER); end
      total++; if (bus.cfg_done !== 1'b1) begin bad++; $display("FAIL fin_done_hold got %b want 1", bus.cfg_done); end
   endtask

   task automatic test_go_ignored;
      int t0, base;
      bit ok, hit;
      base = n_st;
      go(t0);
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.tbl_idx == 8'd1) begin hit = 1'b1; break; end
      end
      total++; if (!hit) begin bad++; $display("FAIL ign_reach_entry1 got 0 want 1"); end
      bus.cfg_go = 1'b1;
      @(posedge clk);
      #1 bus.cfg_go = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.tbl_idx !== 8'd1) begin bad++; $display("FAIL ign_idx got %0d want 1", bus.tbl_idx); end
      total++; if (bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL ign_busy got %b want 1", bus.cfg_busy); end
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL ign_done_timeout got 0 want 1"); end
      total++; if (n_st - base !== NR * PER) begin bad++; $display("FAIL ign_count got %0d want %0d", n_st - base, NR * PER); end
      total++; if (st_a[base+PER] !== t_addr[1]) begin bad++; $display("FAIL ign_order got %h want %h", st_a[base+PER], t_addr[1]); end
   endtask

   task automatic test_gap_drop;
      int t0, base, d;
      bit ok;
      base = n_st;
      go(t0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      force_low = 1'b1;
      repeat (3) @(negedge clk);
      force_low = 1'b0;
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL gap_done_timeout got 0 want 1"); end
      total++; if (st_t[base] !== t0 + 11) begin bad++; $display("FAIL gap_restart_time got %0d want %0d", st_t[base], t0 + 11); end
      d = (PER == 2) ? 17 : 18;
      total++; if (st_t[base+1] - st_t[base] !== d) begin bad++; $display("FAIL gap_next_time got %0d want %0d", st_t[base+1] - st_t[base], d); end
      total++; if (st_a[base] !== t_addr[0]) begin bad++; $display("FAIL gap_addr got %h want %h", st_a[base], t_addr[0]); end
   endtask

   task automatic test_reset_mid;
      int t0, base;
      bit ok, hit;
      go(t0);
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.tbl_idx == 8'd1 && !bus.spi_ready) begin hit = 1'b1; break; end
      end
      total++; if (!hit) begin bad++; $display("FAIL mid_reach got 0 want 1"); end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      total++; if (bus.spi_addr !== 15'd0) begin bad++; $display("FAIL mid_rst_addr got %h want 0", bus.spi_addr); end
      total++; if (bus.spi_wdata !== 8'd0) begin bad++; $display("FAIL mid_rst_wdata got %h want 0", bus.spi_wdata); end
      total++; if (bus.tbl_idx !== 8'd0) begin bad++; $display("FAIL mid_rst_idx got %h want 0", bus.tbl_idx); end
      total++; if (bus.cfg_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b want 0", bus.cfg_busy); end
      total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got %b want 0", bus.cfg_done); end
      total++; if (bus.spi_rw !== 1'b0) begin bad++; $display("FAIL mid_rst_rw got %b want 0", bus.spi_rw); end
      total++; if (bus.spi_start !== 1'b0) begin bad++; $display("FAIL mid_rst_start got %b want 0", bus.spi_start); end
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      base = n_st;
      go(t0);
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL mid_done_timeout got 0 want 1"); end
      total++; if (st_a[base] !== t_addr[0]) begin bad++; $display("FAIL mid_restart_addr got %h want %h", st_a[base], t_addr[0]); end
      total++; if (st_t[base] !== t0 + 6) begin bad++; $display("FAIL mid_restart_time got %0d want %0d", st_t[base], t0 + 6); end
      total++; if (n_st - base !== NR * PER) begin bad++; $display("FAIL mid_count got %0d want %0d", n_st - base, NR * PER); end
   endtask

`ifdef SPI_CFG_READBACK_EN
   task automatic test_readback_err;
      int t0, base;
      bit ok;
      corrupt = 1'b1;
      base = n_st;
      go(t0);
      wait_done(ok);
      corrupt = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL rb_done_timeout got 0 want 1"); end
      total++; if (bus.cfg_err !== 1'b1) begin bad++; $display("FAIL rb_err got %b want 1", bus.cfg_err); end
      total++; if (bus.err_idx !== 8'd1) begin bad++; $display("FAIL rb_err_idx got %0d want 1", bus.err_idx); end
      total++; if (n_st - base !== 2 * NR) begin bad++; $display("FAIL rb_count got %0d want %0d", n_st - base, 2 * NR); end
      total++; if (st_a[base+3] !== t_addr[1]) begin bad++; $display("FAIL rb_read_addr got %h want %h", st_a[base+3], t_addr[1]); end
   endtask

   task automatic test_rerun;
      int t0;
      bit ok;
      go(t0);
      @(negedge clk);
      total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rerun_err_clr got %b want 0", bus.cfg_err); end
      total++; if (bus.cfg_done !== 1'b0) begin bad++; $display("FAIL rerun_done_clr got %b want 0", bus.cfg_done); end
      total++; if (bus.cfg_busy !== 1'b1) begin bad++; $display("FAIL rerun_busy got %b want 1", bus.cfg_busy); end
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL rerun_done_timeout got 0 want 1"); end
      total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rerun_err got %b want 0", bus.cfg_err); end
   endtask
`else
   task automatic test_write_only;
      int t0, base;
      bit ok;
      corrupt = 1'b1;
      base = n_st;
      go(t0);
      wait_done(ok);
      corrupt = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL wo_done_timeout got 0 want 1"); end
      total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL wo_err got %b want 0", bus.cfg_err); end
      total++; if (bus.err_idx !== 8'd0) begin bad++; $display("FAIL wo_err_idx got %0d want 0", bus.err_idx); end
      total++; if (n_st - base !== NR) begin bad++; $display("FAIL wo_count got %0d want %0d", n_st - base, NR); end
      total++; if (st_rw[base+2] !== 1'b0) begin bad++; $display("FAIL wo_rw got %b want 0", st_rw[base+2]); end
   endtask
`endif

   initial begin
      bus.cfg_go = 1'b0;
      test_reset();
      test_sequence();
      test_go_ignored();
      test_gap_drop();
      test_reset_mid();
`ifdef SPI_CFG_READBACK_EN
      test_readback_err();
      test_rerun();
`else
      test_write_only();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
